// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, optional two-entry skid
// buffer, synchronous flush and a saturating stall-cycle counter.
module pipe_skid_reg #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 160,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // State encoding is {s_valid, m_valid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic              in_fire;
  logic              out_fire;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = m_valid & out_ready;
  assign out_valid = m_valid;
  // m_ctrl is zeroed whenever m_valid drops, so no output gating is needed.
  assign out_ctrl  = m_ctrl;
  assign out_data  = m_data;

  // Saturating stall counter; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (m_valid && !out_ready && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      state_t            state;
      logic [CTRL_W-1:0] s_ctrl;
      logic [DATA_W-1:0] s_data;

      assign m_valid  = state[0];
      assign in_ready = ~state[1];

      always_ff @(posedge clk) begin
        if (rst) begin
          state  <= EMPTY;
          m_ctrl <= '0;
          m_data <= '0;
          s_ctrl <= '0;
          s_data <= '0;
        end else if (flush) begin
          state  <= EMPTY;
          m_ctrl <= '0;
          s_ctrl <= '0;
        end else begin
          case (state)
            EMPTY: begin
              if (in_fire) begin
                state  <= ONE;
                m_ctrl <= in_ctrl;
                m_data <= in_data;
              end
            end
            ONE: begin
              if (in_fire && out_fire) begin
                m_ctrl <= in_ctrl;
                m_data <= in_data;
              end else if (out_fire) begin
                state  <= EMPTY;
                m_ctrl <= '0;
              end else if (in_fire) begin
                state  <= FULL;
                s_ctrl <= in_ctrl;
                s_data <= in_data;
              end
            end
            FULL: begin
              // in_ready is low here, so only the drain path applies.
              if (out_fire) begin
                state  <= ONE;
                m_ctrl <= s_ctrl;
                m_data <= s_data;
                s_ctrl <= '0;
              end
            end
            default: begin
              state  <= EMPTY;
              m_ctrl <= '0;
              s_ctrl <= '0;
            end
          endcase
        end
      end
    end else begin : g_single
      assign in_ready = ~m_valid | out_ready;

      always_ff @(posedge clk) begin
        if (rst) begin
          m_valid <= 1'b0;
          m_ctrl  <= '0;
          m_data  <= '0;
        end else if (flush) begin
          m_valid <= 1'b0;
          m_ctrl  <= '0;
        end else if (in_fire) begin
          m_valid <= 1'b1;
          m_ctrl  <= in_ctrl;
          m_data  <= in_data;
        end else if (out_fire) begin
          m_valid <= 1'b0;
          m_ctrl  <= '0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: one skid instance and one single-register
// instance share the drivers; in_valid is steered to one of them by sel.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  in_ctrl;
  logic [15:0] in_data;
  logic        sel;

  logic        a_in_ready, a_out_valid;
  logic [7:0]  a_out_ctrl;
  logic [15:0] a_out_data;
  logic [3:0]  a_stall;
  logic        b_in_ready, b_out_valid;
  logic [7:0]  b_out_ctrl;
  logic [15:0] b_out_data;
  logic [3:0]  b_stall;

  logic        a_in_valid, b_in_valid;
  assign a_in_valid = in_valid & ~sel;
  assign b_in_valid = in_valid & sel;

  int vectors = 0;
  int miscompares = 0;
  logic [23:0] qa[$];
  logic [23:0] qb[$];

  always #5 clk = ~clk;

  pipe_skid_reg #(.CTRL_W(8), .DATA_W(16), .SKID(1), .CNT_W(4)) u_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_ctrl(a_out_ctrl),
    .out_data(a_out_data), .stall_cnt(a_stall)
  );

  pipe_skid_reg #(.CTRL_W(8), .DATA_W(16), .SKID(0), .CNT_W(4)) u_single (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl),
    .out_data(b_out_data), .stall_cnt(b_stall)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop the expected entry on every output transfer.
  always @(negedge clk) begin
    if (!rst && a_out_valid && out_ready) begin
      if (qa.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL skid_unexpected: got 0x%0h, expected no entry", {a_out_ctrl, a_out_data});
      end else begin
        check("skid_out", 32'({a_out_ctrl, a_out_data}), 32'(qa.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid && out_ready) begin
      if (qb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL single_unexpected: got 0x%0h, expected no entry", {b_out_ctrl, b_out_data});
      end else begin
        check("single_out", 32'({b_out_ctrl, b_out_data}), 32'(qb.pop_front()));
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = 8'h00; in_data = 16'h0000; sel = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_out_ctrl", 32'(a_out_ctrl), 32'd0);
    check("rst_out_data", 32'(a_out_data), 32'd0);
    check("rst_stall", 32'(a_stall), 32'd0);
    check("rst_in_ready", 32'(a_in_ready), 32'd1);

    // Streaming through the skid stage
    out_ready = 1'b1; in_ctrl = 8'h1F;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      check("stream_in_ready", 32'(a_in_ready), 32'd1);
      qa.push_back({8'h1F, 16'(i)});
      tick();
      check("stream_latency", 32'(a_out_data), 32'(i));
    end
    in_valid = 1'b0;
    tick();
    check("stream_drained", 32'(a_out_valid), 32'd0);
    check("stream_stall", 32'(a_stall), 32'd0);

    // Skid fill and drain
    out_ready = 1'b0; in_ctrl = 8'hA5;
    in_valid = 1'b1; in_data = 16'h000A; qa.push_back({8'hA5, 16'h000A});
    tick();
    check("skid_a_held", 32'(a_out_data), 32'h000A);
    check("skid_ready_one", 32'(a_in_ready), 32'd1);
    in_data = 16'h000B; qa.push_back({8'hA5, 16'h000B});
    tick();
    check("skid_ready_full", 32'(a_in_ready), 32'd0);
    check("skid_stall1", 32'(a_stall), 32'd1);
    in_data = 16'h000C;
    tick(); tick();
    check("skid_c_held", 32'(a_out_data), 32'h000A);
    check("skid_ready_held", 32'(a_in_ready), 32'd0);
    check("skid_stall3", 32'(a_stall), 32'd3);
    out_ready = 1'b1;
    tick();
    check("skid_b_main", 32'(a_out_data), 32'h000B);
    check("skid_ready_back", 32'(a_in_ready), 32'd1);
    qa.push_back({8'hA5, 16'h000C});
    tick();
    check("skid_c_main", 32'(a_out_data), 32'h000C);
    in_valid = 1'b0;
    tick();
    check("skid_empty", 32'(a_out_valid), 32'd0);
    check("skid_stall_final", 32'(a_stall), 32'd3);
    check("skid_queue_empty", 32'(qa.size()), 32'd0);

    // Flush in FULL with out_ready low
    out_ready = 1'b0; in_ctrl = 8'h3C; in_valid = 1'b1;
    in_data = 16'h0011; tick();
    in_data = 16'h0012; tick();
    check("flush_pre_full", 32'(a_in_ready), 32'd0);
    flush = 1'b1; in_data = 16'h000D;
    qa.delete();
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 32'(a_out_valid), 32'd0);
    check("flush_out_ctrl", 32'(a_out_ctrl), 32'd0);
    check("flush_in_ready", 32'(a_in_ready), 32'd1);
    check("flush_stall", 32'(a_stall), 32'd5);
    out_ready = 1'b1;
    tick(); tick();
    check("flush_no_d", 32'(a_out_valid), 32'd0);

    // Reset beats flush and a concurrent in_fire
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0033; tick();
    tick();
    rst = 1'b1; flush = 1'b1; in_data = 16'h0044;
    qa.delete();
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check("rprio_out_valid", 32'(a_out_valid), 32'd0);
    check("rprio_out_ctrl", 32'(a_out_ctrl), 32'd0);
    check("rprio_out_data", 32'(a_out_data), 32'd0);
    check("rprio_stall", 32'(a_stall), 32'd0);
    check("rprio_in_ready", 32'(a_in_ready), 32'd1);

    // Stall counter saturation
    in_valid = 1'b1; in_data = 16'h0055; in_ctrl = 8'h77; tick();
    in_valid = 1'b0;
    repeat (20) tick();
    check("sat_stall", 32'(a_stall), 32'd15);
    flush = 1'b1; qa.delete(); tick(); flush = 1'b0;
    check("sat_after_flush", 32'(a_stall), 32'd15);
    check("sat_flush_valid", 32'(a_out_valid), 32'd0);

    // Single-register mode
    rst = 1'b1; tick(); rst = 1'b0; sel = 1'b1;
    out_ready = 1'b1; in_ctrl = 8'h1F;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 16'(16'h0020 + i);
      check("s0_in_ready", 32'(b_in_ready), 32'd1);
      qb.push_back({8'h1F, 16'(16'h0020 + i)});
      tick();
      check("s0_latency", 32'(b_out_data), 32'(16'h0020 + i));
    end
    in_valid = 1'b0;
    tick();
    check("s0_drained", 32'(b_out_valid), 32'd0);
    check("s0_stall0", 32'(b_stall), 32'd0);

    out_ready = 1'b0; in_ctrl = 8'h5A; in_valid = 1'b1; in_data = 16'h003A;
    #1 check("s0_ready_empty", 32'(b_in_ready), 32'd1);
    qb.push_back({8'h5A, 16'h003A});
    tick();
    check("s0_ready_blocked", 32'(b_in_ready), 32'd0);
    in_data = 16'h003B;
    tick(); tick();
    check("s0_no_absorb", 32'(b_out_data), 32'h003A);
    check("s0_stall2", 32'(b_stall), 32'd2);
    out_ready = 1'b1;
    #1 check("s0_ready_comb", 32'(b_in_ready), 32'd1);
    qb.push_back({8'h5A, 16'h003B});
    tick();
    check("s0_b_main", 32'(b_out_data), 32'h003B);
    in_valid = 1'b0;
    tick();
    check("s0_empty", 32'(b_out_valid), 32'd0);
    check("s0_out_ctrl_zero", 32'(b_out_ctrl), 32'd0);

    tick();
    check("final_qa", 32'(qa.size()), 32'd0);
    check("final_qb", 32'(qb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and a stall-cycle counter. It sits between any two stages of the processor pipeline (ID→EXE, EXE→MEM, MEM→WB). It lets a downstream stage back-pressure without a combinational ready path through the stage. A flush squashes all held instructions into bubbles whose control bits are zero.

## Interface

Parameters:
- CTRL_W, default 8: control bundle width (WB_EN, MEM_R_EN, MEM_W_EN, S, B, …). These bits are forced to zero whenever the output is invalid.
- DATA_W, default 160: payload width (PC, Val_Rn, Val_Rm, immediates, Dest, status). The payload is never cleared except by reset.
- SKID, default 1:
  - 1 = two-entry skid buffer with a registered in_ready.
  - 0 = single register with a combinational in_ready.
- CNT_W, default 16: stall counter width.

Ports:
- clk, input, 1: clock. Single clock domain.
- rst, input, 1: reset. Synchronous, active-high.
- flush, input, 1: synchronous squash of all held entries.
- in_valid, input, 1: upstream entry valid.
- in_ready, output, 1: stage can accept an entry this cycle.
- in_ctrl, input, CTRL_W: upstream control bundle.
- in_data, input, DATA_W: upstream payload.
- out_valid, output, 1: main entry valid.
- out_ready, input, 1: downstream accepts.
- out_ctrl, output, CTRL_W: main control, gated to 0 when out_valid=0.
- out_data, output, DATA_W: main payload.
- stall_cnt, output, CNT_W: saturating count of stall cycles.

## Operation

Handshake events:
- in_fire = in_valid & in_ready.
- out_fire = out_valid & out_ready.

Storage:
- Main entry (m_valid, m_ctrl, m_data) drives the outputs.
- Skid entry (s_valid, s_ctrl, s_data) exists only when SKID=1.

in_ready:
- SKID=1: in_ready = ~s_valid, a pure register output.
- SKID=0: in_ready = ~m_valid | out_ready.

State machine for SKID=1 (state encoded as {s_valid, m_valid}):
- EMPTY:
  - in_fire → ONE (in loaded into main).
- ONE:
  - in_fire & out_fire → ONE (main replaced by in).
  - out_fire only → EMPTY.
  - in_fire only → FULL (in loaded into skid).
  - neither → hold.
- FULL (in_ready=0):
  - out_fire → ONE (skid moves to main; skid cleared).
  - no out_fire → hold.

SKID=0 mode:
- Main loads on in_fire.
- m_valid clears on out_fire without in_fire.

Ordering and loss:
- Order is preserved.
- No entry is ever duplicated or dropped, except by flush.

Flush:
- Any state → EMPTY at the next edge. m_valid, s_valid and m_ctrl are cleared.
- An in_fire in the same cycle is discarded.
- in_ready is not masked during flush.
- An out_fire in the flush cycle still counts as a transfer for downstream.

stall_cnt:
- Increments by 1 on each cycle with out_valid & ~out_ready.
- Saturates at 2^CNT_W−1.
- Cleared only by rst; flush does not clear it.

Priority: rst > flush > handshake updates.

## Timing

- Reset values (after the edge where rst=1):
  - out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0.
  - Both entries invalid and zero.
  - in_ready=1.
- Latency: an entry accepted on edge N appears on out_* after edge N (one cycle). It arrives one cycle later if it was parked in skid.
- Throughput: one entry per cycle while out_ready=1.
- Back-pressure in SKID=1 mode:
  - One further entry is absorbed after out_ready falls.
  - in_ready drops the cycle after the skid entry fills.
  - in_ready rises the cycle after the skid entry drains.
- Reset mid-operation: all contents are lost and no partial transfer occurs. in_ready=1 on the cycle after the rst edge.
- Flush in FULL state with out_ready=0: both entries are squashed. out_valid=0 and out_ctrl=0 at the next cycle.
- stall_cnt updates on the same edge as the stall cycle it counts. It is readable combinationally from the register.

## Test plan

- **Streaming:**
  - Stimulus: reset, then in_valid=1 for 8 cycles with in_data=1..8, in_ctrl=8'h1F, out_ready=1.
  - Required: out_data=1..8 on consecutive cycles, one cycle late; stall_cnt=0; in_ready constantly 1.
- **Skid fill and drain:**
  - Stimulus: out_ready=0 while sending A=0xA, B=0xB, C=0xC.
  - Required: A held on output; B accepted into skid; in_ready=0 from the next cycle; C held upstream. After out_ready=1, output is A, B, C in order; stall_cnt equals the number of stalled cycles.
- **Flush:**
  - Stimulus: in state FULL, assert flush for one cycle with in_valid=1, in_data=0xD.
  - Required: next cycle out_valid=0, out_ctrl=0; 0xD never appears; in_ready=1.
- **Reset priority:**
  - Stimulus: rst=1 together with flush=1 and in_fire.
  - Required: all outputs at reset values; stall_cnt=0 next cycle.
- **Saturation:**
  - Stimulus: CNT_W=4, out_valid held with out_ready=0 for 20 cycles.
  - Required: stall_cnt stops at 15; flush leaves it at 15.
- **SKID=0 mode:**
  - Stimulus: repeat the streaming and back-pressure cases.
  - Required: in_ready follows ~m_valid|out_ready combinationally; no entry absorbed beyond the main register.
